// File: rtl/seq_match_pkg.sv
// Shared state encodings and index-width helper for the sequence word matcher.
package seq_match_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SEARCH = 1'b1
  } state_t;

  function automatic int unsigned idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/word_cmp.sv
// Masked word equality: bits with mask=1 are excluded from the comparison.
module word_cmp #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] mask,
  output logic             eq
);

  assign eq = (((a ^ b) & ~mask) == '0);

endmodule

// File: rtl/seq_word_match.sv
// Programmable DEPTH-word sequence detector with saturating hit counter.
// Optional per-bit don't-care masks are enabled by defining SEQ_WORD_MATCH_MASK_EN.
module seq_word_match
  import seq_match_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic                     cfg_we,
  input  logic [idx_w(DEPTH)-1:0]  cfg_idx,
  input  logic [WIDTH-1:0]         cfg_data,
`ifdef SEQ_WORD_MATCH_MASK_EN
  input  logic [WIDTH-1:0]         cfg_mask,
`endif
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     flag,
  output logic                     busy,
  output logic [idx_w(DEPTH)-1:0]  progress,
  output logic [CNT_W-1:0]         match_cnt
);

  localparam int unsigned IDXW = idx_w(DEPTH);

  state_t             state, state_n;
  logic [IDXW-1:0]    progress_n;
  logic               flag_n;
  logic [CNT_W-1:0]   cnt_n;
  logic [WIDTH-1:0]   pattern [DEPTH];
  logic [WIDTH-1:0]   cur_mask, first_mask;
  logic               hit_cur, hit_first;
  logic               cfg_ok;

`ifdef SEQ_WORD_MATCH_MASK_EN
  logic [WIDTH-1:0]   mask [DEPTH];
  assign cur_mask   = mask[progress];
  assign first_mask = mask[0];
`else
  assign cur_mask   = '0;
  assign first_mask = '0;
`endif

  word_cmp #(.WIDTH(WIDTH)) u_cmp_cur (
    .a    (in_data),
    .b    (pattern[progress]),
    .mask (cur_mask),
    .eq   (hit_cur)
  );

  word_cmp #(.WIDTH(WIDTH)) u_cmp_first (
    .a    (in_data),
    .b    (pattern[0]),
    .mask (first_mask),
    .eq   (hit_first)
  );

  assign busy   = (state == ST_SEARCH);
  assign cfg_ok = (state == ST_IDLE) && cfg_we && (32'(cfg_idx) < DEPTH);

  always_comb begin
    state_n    = state;
    progress_n = progress;
    flag_n     = 1'b0;
    cnt_n      = match_cnt;
    unique case (state)
      ST_IDLE: begin
        if (arm) begin
          state_n    = ST_SEARCH;
          progress_n = '0;
          cnt_n      = '0;
        end
      end
      ST_SEARCH: begin
        // Disarm takes priority over a coincident final-word hit.
        if (!arm) begin
          state_n    = ST_IDLE;
          progress_n = '0;
        end else if (in_valid) begin
          if (hit_cur) begin
            if (progress == IDXW'(DEPTH - 1)) begin
              flag_n     = 1'b1;
              progress_n = '0;
              if (match_cnt != '1) cnt_n = match_cnt + CNT_W'(1);
            end else begin
              progress_n = progress + IDXW'(1);
            end
          end else begin
            progress_n = hit_first ? IDXW'(1) : '0;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      progress  <= '0;
      flag      <= 1'b0;
      match_cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pattern[i] <= '0;
`ifdef SEQ_WORD_MATCH_MASK_EN
        mask[i]    <= '0;
`endif
      end
    end else begin
      state     <= state_n;
      progress  <= progress_n;
      flag      <= flag_n;
      match_cnt <= cnt_n;
      if (cfg_ok) begin
        pattern[cfg_idx] <= cfg_data;
`ifdef SEQ_WORD_MATCH_MASK_EN
        mask[cfg_idx]    <= cfg_mask;
`endif
      end
    end
  end

endmodule
